tcp_tx_arbiter: RTL
===================

Name: tcp_tx_arbiter

Overview:
Round-robin scheduler that shares the single SiTCP TCP transmit byte port (TCP_TX_WR/TCP_TX_DATA, flow-controlled by TCP_TX_FULL) between NCH first-word-fall-through source FIFOs.
- Grants one source at a time for a burst of up to BURST_LEN bytes.
- Sits between user data FIFOs and the SiTCP wrapper, in the CLK domain.
- Honours connection state (TCP_OPEN_ACK) and the almost-full back-pressure.

Parameters:
- NCH, 2, number of requesters (2..4)
- BURST_LEN, 16'd256, maximum bytes per grant (1..65535)

Ports:
- CLK  in  1  system clock; all logic on its rising edge
- SYS_RSTn  in  1  synchronous, active-low reset
- TCP_OPEN_ACK  in  1  connection established from SiTCP
- TCP_TX_FULL  in  1  SiTCP TX almost-full
- TCP_TX_WR  out  1  registered write strobe to SiTCP
- TCP_TX_DATA  out  8  registered write data to SiTCP
- REQ_VALID  in  NCH  per source: FIFO not empty (FWFT)
- REQ_DATA  in  8*NCH  per source head byte; source i on bits [8i+7:8i]
- REQ_RD  out  NCH  per source pop strobe (combinational, one-hot or zero)
- GRANT  out  NCH  one-hot current owner, 0 when idle
- BUSY  out  1  high while not in IDLE

Behaviour:
- Reset (SYS_RSTn=0 at clock edge):
  - state=IDLE; TCP_TX_WR=0; TCP_TX_DATA=8'h00; GRANT=0; REQ_RD=0; burst count=0.
  - LAST=NCH-1, so source 0 wins first. Reset mid-burst aborts with no further pops.
- States: IDLE, HDR (only with macro), BURST.
- IDLE:
  - If TCP_OPEN_ACK=1 and any REQ_VALID=1, pick the first valid source after LAST in ascending modular order.
  - Register GRANT = onehot(pick), clear count, go to BURST (or HDR).
  - Otherwise stay in IDLE.
- BURST, with g = granted source:
  - pop = REQ_VALID[g] & ~TCP_TX_FULL & TCP_OPEN_ACK; REQ_RD[g] = pop in the same cycle.
  - Next edge: TCP_TX_WR<=pop; TCP_TX_DATA<=REQ_DATA[g] when pop, otherwise hold the previous value; count += pop.
  - Exit to IDLE, with LAST<=g and GRANT<=0, when any of:
    - (a) pop & count==BURST_LEN-1;
    - (b) REQ_VALID[g]=0;
    - (c) TCP_OPEN_ACK=0.
  - TCP_TX_FULL=1 alone holds the grant; no pop, count frozen.
- Latency: REQ_VALID rises in IDLE cycle n → REQ_RD in cycle n+1 → TCP_TX_WR high in cycle n+2.
  - One idle cycle separates consecutive bursts.
  - Sustained throughput is 1 byte/cycle within a burst.
- Count is 16-bit and never wraps; the burst ends at exactly BURST_LEN pops.
- Simultaneous FULL and last byte: no pop, so the burst does not end until the pop occurs.
- Simultaneous OPEN_ACK fall and last byte: no pop (OPEN_ACK gates it); go to IDLE.
- TCP_OPEN_ACK=0 in IDLE: no grant, regardless of REQ_VALID.
- At most one REQ_RD bit is high in any cycle; none is high outside BURST/HDR.
- BUSY=1 in HDR and BURST.

Optional Feature:
- Macro TCP_TX_ARB_HDR_EN.
- Defined:
  - IDLE goes to HDR after a grant.
  - In HDR, when ~TCP_TX_FULL & TCP_OPEN_ACK: TCP_TX_WR<=1 and TCP_TX_DATA<={4'hA,2'b00,g[1:0]}, then go to BURST. No REQ_RD is issued in HDR.
  - TCP_OPEN_ACK=0 in HDR: go to IDLE with no write.
  - FULL in HDR: wait.
  - Header bytes do not count toward BURST_LEN. Latency to the first data byte is +1 cycle.
- Undefined: no HDR state; streams are concatenated raw.

Test Plan:
- Single source, count check: OPEN_ACK=1, FULL=0, source 0 holds 5 bytes 01..05, BURST_LEN=256 → TCP_TX_WR high 5 consecutive cycles starting 2 cycles after VALID, data 01..05; then IDLE, LAST=0.
- Burst limit and round-robin: both sources hold 600 bytes, BURST_LEN=256 → grant order 0(256),1(256),0(256),1(256),0(88),1(88); one idle cycle between bursts; 1200 writes total.
- Back-pressure: FULL asserted 10 cycles mid-burst of source 1 → REQ_RD and TCP_TX_WR low for those cycles (WR low from the next edge); no data lost or duplicated; grant retained.
- Disconnect mid-burst: OPEN_ACK drops after 3 of 10 bytes → exactly 3 writes, GRANT=0 next edge, remaining 7 bytes still in the FIFO; no grants while OPEN_ACK=0.
- Reset mid-burst: SYS_RSTn=0 for one cycle after 4 bytes → next edge TCP_TX_WR=0, GRANT=0, BUSY=0; after release, source 0 is granted first if both are valid.
- With TCP_TX_ARB_HDR_EN: source 1 holds 2 bytes AA,BB → writes A1,AA,BB on 3 consecutive cycles.

Source files
------------

// File: rtl/tcp_tx_arbiter.sv
// tcp_tx_arbiter: round-robin scheduler sharing the SiTCP TCP TX byte port
// between NCH first-word-fall-through source FIFOs. Each grant carries a
// burst of up to BURST_LEN bytes, gated by TCP_OPEN_ACK and TCP_TX_FULL.
// Optional macro TCP_TX_ARB_HDR_EN: emit a one-byte header {4'hA,2'b00,src}
// before each burst.
module tcp_tx_arbiter #(
    parameter int          NCH       = 2,
    parameter logic [15:0] BURST_LEN = 16'd256
) (
    input  logic             CLK,
    input  logic             SYS_RSTn,
    input  logic             TCP_OPEN_ACK,
    input  logic             TCP_TX_FULL,
    output logic             TCP_TX_WR,
    output logic [7:0]       TCP_TX_DATA,
    input  logic [NCH-1:0]   REQ_VALID,
    input  logic [8*NCH-1:0] REQ_DATA,
    output logic [NCH-1:0]   REQ_RD,
    output logic [NCH-1:0]   GRANT,
    output logic             BUSY
);

`ifdef TCP_TX_ARB_HDR_EN
    typedef enum logic [1:0] {S_IDLE, S_HDR, S_BURST} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_BURST} state_t;
`endif

    localparam int unsigned N = NCH;

    state_t         state_q;
    logic [1:0]     gidx_q;
    logic [1:0]     last_q;
    logic [NCH-1:0] grant_q;
    logic [15:0]    count_q;
    logic           wr_q;
    logic [7:0]     data_q;

    logic           any_valid;
    logic [1:0]     pick;
    logic [NCH-1:0] pick_onehot;
    logic           valid_g;
    logic [7:0]     data_g;
    logic           pop;
    logic           burst_done;
    logic           burst_exit;

    // Round-robin pick: first valid source after last_q in ascending modular order
    always_comb begin
        pick      = '0;
        any_valid = 1'b0;
        for (int unsigned k = 1; k <= N; k++) begin
            for (int unsigned i = 0; i < N; i++) begin
                if (!any_valid && REQ_VALID[i] && (((32'(last_q) + k) % N) == i)) begin
                    pick      = 2'(i);
                    any_valid = 1'b1;
                end
            end
        end
        for (int unsigned i = 0; i < N; i++) begin
            pick_onehot[i] = (pick == 2'(i));
        end
    end

    // Head-of-FIFO mux for the granted source, pop strobe and exit conditions
    always_comb begin
        valid_g = 1'b0;
        data_g  = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (gidx_q == 2'(i)) begin
                valid_g = REQ_VALID[i];
                data_g  = REQ_DATA[8*i +: 8];
            end
        end
        // SYS_RSTn gates the pop so a reset cycle never drains a byte that is then dropped
        pop        = (state_q == S_BURST) && valid_g && !TCP_TX_FULL && TCP_OPEN_ACK && SYS_RSTn;
        burst_done = pop && (count_q == (BURST_LEN - 16'd1));
        burst_exit = burst_done || !valid_g || !TCP_OPEN_ACK;
        for (int unsigned i = 0; i < N; i++) begin
            REQ_RD[i] = pop && (gidx_q == 2'(i));
        end
    end

    // Scheduler FSM with registered write strobe, data, grant and burst count
    always_ff @(posedge CLK) begin
        if (!SYS_RSTn) begin
            state_q <= S_IDLE;
            wr_q    <= 1'b0;
            data_q  <= '0;
            grant_q <= '0;
            gidx_q  <= '0;
            last_q  <= 2'(NCH - 1);
            count_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    wr_q <= 1'b0;
                    if (TCP_OPEN_ACK && any_valid) begin
                        gidx_q  <= pick;
                        grant_q <= pick_onehot;
                        count_q <= '0;
`ifdef TCP_TX_ARB_HDR_EN
                        state_q <= S_HDR;
`else
                        state_q <= S_BURST;
`endif
                    end
                end
`ifdef TCP_TX_ARB_HDR_EN
                S_HDR: begin
                    if (!TCP_OPEN_ACK) begin
                        wr_q    <= 1'b0;
                        last_q  <= gidx_q;
                        grant_q <= '0;
                        state_q <= S_IDLE;
                    end else if (!TCP_TX_FULL) begin
                        wr_q    <= 1'b1;
                        data_q  <= {4'hA, 2'b00, gidx_q};
                        state_q <= S_BURST;
                    end else begin
                        wr_q <= 1'b0;
                    end
                end
`endif
                S_BURST: begin
                    wr_q <= pop;
                    if (pop) begin
                        data_q <= data_g;
                    end
                    count_q <= count_q + 16'(pop);
                    if (burst_exit) begin
                        last_q  <= gidx_q;
                        grant_q <= '0;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    wr_q    <= 1'b0;
                    grant_q <= '0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign TCP_TX_WR   = wr_q;
    assign TCP_TX_DATA = data_q;
    assign GRANT       = grant_q;
    assign BUSY        = (state_q != S_IDLE);

endmodule
